// File: rtl/mesh_pkg.sv
// Shared types and width helpers for the mesh edge feeder.
package mesh_pkg;

  typedef enum logic [1:0] {
    FILL,
    FULL,
    STREAM
  } feeder_state_e;

  localparam logic EDGE_NORTH = 1'b0;
  localparam logic EDGE_WEST  = 1'b1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mesh_edge_feeder_if.sv
// Host, configuration and mesh-edge signals of the edge feeder.
interface mesh_edge_feeder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CFG_W  = 64
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    flush;
  logic                    start;
  logic                    dir;
  logic                    systolic;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CFG_W-1:0]        cfg_in;
  logic [CFG_W-1:0]        cfg_out;
  logic [LANES-1:0]        north_valid;
  logic [LANES*DATA_W-1:0] north_data;
  logic [LANES-1:0]        west_valid;
  logic [LANES*DATA_W-1:0] west_data;
  logic                    full;
  logic                    done;

  modport master (
    output in_valid, in_data, flush, start, dir, systolic, cfg_valid, cfg_in,
    input  in_ready, cfg_ready, cfg_out, north_valid, north_data, west_valid, west_data,
           full, done
  );

  modport slave (
    input  in_valid, in_data, flush, start, dir, systolic, cfg_valid, cfg_in,
    output in_ready, cfg_ready, cfg_out, north_valid, north_data, west_valid, west_data,
           full, done
  );
endinterface

// File: rtl/mesh_edge_lane.sv
// One edge lane: DEPTH-word operand buffer and the skewed read window into it.
module mesh_edge_lane
  import mesh_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TW       = 3,
  parameter int unsigned LANE_IDX = 0,
  parameter int unsigned WW       = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TW-1:0]     t,
  input  logic              systolic,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] mem [DEPTH];
  int                rel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) mem[k] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Lane i trails lane 0 by i cycles when streaming systolically.
  always_comb begin
    rel   = int'(t) - (systolic ? int'(LANE_IDX) : 0);
    valid = (rel >= 0) && (rel < int'(DEPTH));
    data  = valid ? mem[WW'(rel)] : '0;
  end

endmodule

// File: rtl/mesh_edge_feeder.sv
// Buffers a LANES x DEPTH operand tile and streams it into the north or west mesh edge.
module mesh_edge_feeder
  import mesh_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CFG_W  = 64
) (
  input logic               clk,
  input logic               reset,
  mesh_edge_feeder_if.slave bus
);

  localparam int unsigned LW = cnt_w(LANES);
  localparam int unsigned WW = cnt_w(DEPTH);
  localparam int unsigned TW = cnt_w(DEPTH + LANES);
  localparam logic [TW-1:0] T_ALIGN = TW'(DEPTH);
  localparam logic [TW-1:0] T_SKEW  = TW'(DEPTH + LANES - 1);

  feeder_state_e           state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [WW-1:0]           word_q, word_d;
  logic [TW-1:0]           t_q, t_d;
  logic                    dir_q, dir_d, sys_q, sys_d;
  logic [CFG_W-1:0]        cfg_q, cfg_d;
  logic [LANES-1:0]        nv_q, nv_d, wv_q, wv_d;
  logic [LANES*DATA_W-1:0] nd_q, nd_d, wd_q, wd_d;
  logic                    done_q, done_d;
  logic                    in_ready, full, cfg_ready;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*DATA_W-1:0] lane_data;
  logic                    accept, last_word, stream_end;
  logic [TW-1:0]           t_end;

  assign accept     = bus.in_valid && (state_q == FILL) && !bus.flush;
  assign last_word  = (lane_q == LW'(LANES - 1)) && (word_q == WW'(DEPTH - 1));
  assign t_end      = sys_q ? T_SKEW : T_ALIGN;
  // t runs one past the last beat so the registered done lands after it.
  assign stream_end = (state_q == STREAM) && (t_q == t_end);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mesh_edge_lane #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TW      (TW),
      .LANE_IDX(i)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept && (lane_q == LW'(i))),
      .wr_addr (word_q),
      .wr_data (bus.in_data),
      .t       (t_q),
      .systolic(sys_q),
      .valid   (lane_valid[i]),
      .data    (lane_data[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      lane_q  <= '0;
      word_q  <= '0;
      t_q     <= '0;
      dir_q   <= 1'b0;
      sys_q   <= 1'b0;
      cfg_q   <= '0;
      nv_q    <= '0;
      nd_q    <= '0;
      wv_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      t_q     <= t_d;
      dir_q   <= dir_d;
      sys_q   <= sys_d;
      cfg_q   <= cfg_d;
      nv_q    <= nv_d;
      nd_q    <= nd_d;
      wv_q    <= wv_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    t_d     = '0;
    dir_d   = dir_q;
    sys_d   = sys_q;
    if (bus.flush) begin
      state_d = FILL;
      lane_d  = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (last_word) state_d = FULL;
            if (lane_q == LW'(LANES - 1)) begin
              lane_d = '0;
              word_d = (word_q == WW'(DEPTH - 1)) ? '0 : word_q + WW'(1);
            end else begin
              lane_d = lane_q + LW'(1);
            end
          end
        end
        FULL: begin
          if (bus.start) begin
            state_d = STREAM;
            dir_d   = bus.dir;
            sys_d   = bus.systolic;
          end
        end
        STREAM: begin
          if (stream_end) state_d = FILL;
          else            t_d     = t_q + TW'(1);
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    full      = (state_q == FULL);
    cfg_ready = (state_q != STREAM);
    cfg_d     = (bus.cfg_valid && cfg_ready) ? bus.cfg_in : cfg_q;
    done_d    = stream_end && !bus.flush;
    nv_d      = '0;
    nd_d      = '0;
    wv_d      = '0;
    wd_d      = '0;
    if ((state_q == STREAM) && !bus.flush) begin
      if (dir_q == EDGE_WEST) begin
        wv_d = lane_valid;
        wd_d = lane_data;
      end else begin
        nv_d = lane_valid;
        nd_d = lane_data;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.full        = full;
  assign bus.cfg_ready   = cfg_ready;
  assign bus.cfg_out     = cfg_q;
  assign bus.north_valid = nv_q;
  assign bus.north_data  = nd_q;
  assign bus.west_valid  = wv_q;
  assign bus.west_data   = wd_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_mesh_edge_feeder.sv
// Scoreboard bench for mesh_edge_feeder with LANES=4, DEPTH=4, DATA_W=32.
module tb_mesh_edge_feeder;
  import mesh_pkg::*;

  localparam int L  = 4;
  localparam int D  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [L-1:0]    nv;
    logic [L*DW-1:0] nd;
    logic [L-1:0]    wv;
    logic [L*DW-1:0] wd;
    logic            done;
    logic            cfg_ready;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mesh_edge_feeder_if #(.DATA_W(DW), .LANES(L), .CFG_W(64)) bus ();

  mesh_edge_feeder #(
    .DATA_W(DW),
    .LANES (L),
    .DEPTH (D),
    .CFG_W (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  beat_t       sb[$];
  logic [31:0] tile [L][D];
  logic [63:0] cfg_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected edge contents for stream beat t (t<0: idle edge).
  function automatic beat_t make_beat(int t, bit d, bit s, bit done, bit cfg_rdy);
    beat_t b;
    b.nv = '0; b.nd = '0; b.wv = '0; b.wd = '0;
    b.done = done;
    b.cfg_ready = cfg_rdy;
    for (int i = 0; i < L; i++) begin
      int rel = t - (s ? i : 0);
      if (t >= 0 && rel >= 0 && rel < D) begin
        if (d) begin
          b.wv[i] = 1'b1;
          b.wd[i*DW +: DW] = tile[i][rel];
        end else begin
          b.nv[i] = 1'b1;
          b.nd[i*DW +: DW] = tile[i][rel];
        end
      end
    end
    return b;
  endfunction

  task automatic load_tile(input int base, input bit early_start);
    for (int n = 0; n < L * D; n++) begin
      if (n == 0) check_eq("in_ready_fill", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(base + n);
      bus.start    = early_start;
      tile[n % L][n / L] = 32'(base + n);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq("in_ready_full", bus.in_ready, 1'b0);
    if (early_start) begin
      bus.in_data = 32'h999;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_eq("full", bus.full, 1'b1);
  endtask

  task automatic run_stream(input bit d, input bit s, input bit cfg_during);
    int    tn;
    beat_t e;
    tn = D + (s ? L - 1 : 0);
    bus.dir      = d;
    bus.systolic = s;
    bus.start    = 1'b1;
    sb.push_back(make_beat(-1, d, s, 1'b0, 1'b0));
    for (int k = 0; k < tn; k++) sb.push_back(make_beat(k, d, s, 1'b0, 1'b0));
    sb.push_back(make_beat(-1, d, s, 1'b1, 1'b1));
    sb.push_back(make_beat(-1, d, s, 1'b0, 1'b1));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dir      = ~d;
    bus.systolic = ~s;
    for (int j = 0; j < tn + 3; j++) begin
      if (sb.size() == 0) begin
        check_eq("scoreboard_empty", 1'b1, 1'b0);
        break;
      end
      e = sb.pop_front();
      check_eq($sformatf("north_valid[%0d]", j), bus.north_valid, e.nv);
      check_eq($sformatf("north_data[%0d]", j), bus.north_data, e.nd);
      check_eq($sformatf("west_valid[%0d]", j), bus.west_valid, e.wv);
      check_eq($sformatf("west_data[%0d]", j), bus.west_data, e.wd);
      check_eq($sformatf("done[%0d]", j), bus.done, e.done);
      check_eq($sformatf("cfg_ready[%0d]", j), bus.cfg_ready, e.cfg_ready);
      check_eq($sformatf("cfg_out[%0d]", j), bus.cfg_out, cfg_exp);
      if (cfg_during && j == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_in    = 64'hDEAD_BEEF_0000_0001;
      end
      if (j == tn) bus.cfg_valid = 1'b0;
      if (j < tn + 2) @(negedge clk);
    end
  endtask

  initial begin
    beat_t e;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.start    = 1'b0;
    bus.dir      = 1'b0;
    bus.systolic = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_in   = '0;
    cfg_exp      = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 1'b1);
    check_eq("rst_cfg_ready", bus.cfg_ready, 1'b1);
    check_eq("rst_full", bus.full, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_north_valid", bus.north_valid, '0);
    check_eq("rst_west_valid", bus.west_valid, '0);
    check_eq("rst_north_data", bus.north_data, '0);
    check_eq("rst_cfg_out", bus.cfg_out, '0);

    bus.cfg_valid = 1'b1;
    bus.cfg_in    = 64'h1234;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    cfg_exp = 64'h1234;
    check_eq("cfg_load", bus.cfg_out, cfg_exp);

    // Aligned north
    load_tile(0, 1'b0);
    run_stream(1'b0, 1'b0, 1'b0);

    // Systolic west, config offered mid-stream then re-sent
    load_tile(0, 1'b0);
    run_stream(1'b1, 1'b1, 1'b1);
    check_eq("cfg_ready_after", bus.cfg_ready, 1'b1);
    bus.cfg_valid = 1'b1;
    bus.cfg_in    = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    cfg_exp = 64'hDEAD_BEEF_0000_0001;
    check_eq("cfg_resent", bus.cfg_out, cfg_exp);

    // Backpressure: 17th word dropped, early start ignored
    load_tile(100, 1'b1);
    run_stream(1'b0, 1'b0, 1'b0);

    // Reset mid-stream at beat 2
    load_tile(50, 1'b0);
    bus.dir = 1'b1; bus.systolic = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    e = make_beat(2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("mid_west_valid", bus.west_valid, e.wv);
    check_eq("mid_west_data", bus.west_data, e.wd);
    reset = 1'b1;
    #1;
    cfg_exp = '0;
    check_eq("arst_west_valid", bus.west_valid, '0);
    check_eq("arst_north_valid", bus.north_valid, '0);
    check_eq("arst_done", bus.done, 1'b0);
    check_eq("arst_in_ready", bus.in_ready, 1'b1);
    check_eq("arst_cfg_out", bus.cfg_out, cfg_exp);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_done[%0d]", c), bus.done, 1'b0);
      check_eq($sformatf("post_rst_wv[%0d]", c), bus.west_valid, '0);
    end

    // Flush beats start in FULL
    load_tile(200, 1'b0);
    bus.flush = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    check_eq("flush_in_ready", bus.in_ready, 1'b1);
    check_eq("flush_full", bus.full, 1'b0);
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("flush_nv[%0d]", c), bus.north_valid, '0);
      check_eq($sformatf("flush_wv[%0d]", c), bus.west_valid, '0);
      check_eq($sformatf("flush_done[%0d]", c), bus.done, 1'b0);
      @(negedge clk);
    end
    load_tile(300, 1'b0);
    run_stream(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
